// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC generation, in-order fetch buffer tagged with PC,
// valid/ready handoff to decode, and redirect with discard of stale in-flight responses.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc
);

   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]      pc;
   logic [31:0]      pc_q   [DEPTH];
   logic [31:0]      inst_q [DEPTH];
   logic [DEPTH-1:0] filled_q;
   logic [AW-1:0]    head, tail, fptr;
   logic [CW-1:0]    alloc_cnt;   // entries allocated and not yet popped
   logic [CW-1:0]    unfill_cnt;  // allocated entries still waiting for data
   logic [CW-1:0]    drop_cnt;    // responses still owed for fetches killed by a redirect
   logic [CW:0]      inflight;

   logic push, pop, do_fill, do_drop, rv_owed;

   assign inflight  = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
   assign imem_req  = rst_n && !redirect_valid && (inflight < (CW+1)'(DEPTH));
   assign imem_addr = pc;

   assign id_valid = !redirect_valid && (alloc_cnt != '0) && filled_q[head];
   assign id_inst  = id_valid ? inst_q[head] : NOP;
   assign id_pc    = id_valid ? pc_q[head]   : '0;

   assign push    = imem_req && imem_gnt;
   assign pop     = id_valid && id_ready;
   assign do_drop = imem_rvalid && (drop_cnt != '0);
   assign do_fill = imem_rvalid && (drop_cnt == '0) && (unfill_cnt != '0);
   assign rv_owed = imem_rvalid && ((drop_cnt != '0) || (unfill_cnt != '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         filled_q   <= '0;
         head       <= '0;
         tail       <= '0;
         fptr       <= '0;
         alloc_cnt  <= '0;
         unfill_cnt <= '0;
         drop_cnt   <= '0;
      end else if (redirect_valid) begin
         // Every unfilled entry becomes an owed response; one arriving now is already paid off.
         pc         <= {redirect_pc[31:2], 2'b00};
         filled_q   <= '0;
         head       <= '0;
         tail       <= '0;
         fptr       <= '0;
         alloc_cnt  <= '0;
         unfill_cnt <= '0;
         drop_cnt   <= drop_cnt + unfill_cnt - CW'(rv_owed);
      end else begin
         if (push) begin
            filled_q[tail] <= 1'b0;
            tail           <= tail + AW'(1);
            pc             <= pc + 32'd4;
         end
         if (do_fill) begin
            filled_q[fptr] <= 1'b1;
            fptr           <= fptr + AW'(1);
         end
         if (do_drop)
            drop_cnt <= drop_cnt - CW'(1);
         if (pop)
            head <= head + AW'(1);
         alloc_cnt  <= alloc_cnt + CW'(push) - CW'(pop);
         unfill_cnt <= unfill_cnt + CW'(push) - CW'(do_fill);
      end
   end

   // Payload storage needs no reset; validity lives in filled_q and the counters.
   always_ff @(posedge clk) begin
      if (!redirect_valid && push)
         pc_q[tail] <= pc;
      if (!redirect_valid && do_fill)
         inst_q[fptr] <= imem_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst_n && imem_rvalid)
         assert (rv_owed);
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random bench for fetch_unit: a memory model answers grants in order,
// and a scoreboard of granted PCs is matched against every decode handoff.
module tb_fetch_unit;

   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_inst;
   logic [31:0] id_pc;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
   );

   int          checks = 0, failures = 0;
   int          cyc = 0, delivered = 0, grants = 0;
   int          gnt_pct = 100, rdy_pct = 100, dmin = 1, dmax = 1, redir_pct = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] last_pc = '0;
   logic [31:0] sb_q [$];
   pend_t       pend [$];

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs at negedge, update models, advance.
   task automatic step(input logic redir, input logic [31:0] rpc);
      logic [31:0] e;
      pend_t       p;
      imem_gnt       = ($urandom_range(99) < gnt_pct);
      id_ready       = ($urandom_range(99) < rdy_pct);
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem(pend[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      if (redir) begin
         chk("req_in_redirect", {31'b0, imem_req}, 32'd0);
         chk("idv_in_redirect", {31'b0, id_valid}, 32'd0);
      end
      if (imem_req === 1'b1)
         chk("imem_addr", imem_addr, exp_pc);
      if (sb_q.size() >= DEPTH)
         chk("req_at_full", {31'b0, imem_req}, 32'd0);
      if (id_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_delivery", {31'b0, id_valid}, 32'd0);
         end else begin
            e = sb_q[0];
            chk("id_pc", id_pc, e);
            chk("id_inst", id_inst, mem(e));
         end
      end else begin
         chk("idle_inst", id_inst, NOP);
         chk("idle_pc", id_pc, 32'd0);
      end
      if (imem_rvalid)
         pend.delete(0);
      if (redir) begin
         sb_q.delete();
         exp_pc = {rpc[31:2], 2'b00};
      end else begin
         if (id_valid === 1'b1 && id_ready && sb_q.size() > 0) begin
            last_pc = sb_q.pop_front();
            delivered++;
         end
         if (imem_req === 1'b1 && imem_gnt) begin
            sb_q.push_back(exp_pc);
            p.addr = exp_pc;
            p.due  = cyc + int'($urandom_range(dmax, dmin));
            pend.push_back(p);
            exp_pc += 32'd4;
            grants++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      redirect_valid = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      id_ready       = 1'b0;
      rst_n          = 1'b0;
      #2;
      chk({tag, "_req"},  {31'b0, imem_req}, 32'd0);
      chk({tag, "_idv"},  {31'b0, id_valid}, 32'd0);
      chk({tag, "_inst"}, id_inst, NOP);
      chk({tag, "_pc"},   id_pc, 32'd0);
      chk({tag, "_addr"}, imem_addr, RESET_PC);
      pend.delete();
      sb_q.delete();
      exp_pc = RESET_PC;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_delivery(input string tag, input logic [31:0] first_pc);
      int d0;
      d0 = delivered;
      for (int i = 0; i < 40 && delivered == d0; i++)
         step(1'b0, '0);
      chk({tag, "_delivered"}, delivered, d0 + 1);
      chk({tag, "_first_pc"}, last_pc, first_pc);
   endtask

   initial begin
      int g0, d0;

      // 1: streaming from reset, one-cycle memory latency
      do_reset("rst0");
      gnt_pct = 100; rdy_pct = 100; dmin = 1; dmax = 1;
      step(1'b0, '0);
      step(1'b0, '0);
      chk("t1_idv_c2", {31'b0, id_valid}, 32'd1);
      chk("t1_pc_c2", id_pc, 32'd0);
      for (int i = 0; i < 10; i++) step(1'b0, '0);
      chk("t1_progress", {31'b0, (delivered >= 3)}, 32'd1);

      // 2: decode stall fills the buffer, release drains it in order
      do_reset("rst2");
      rdy_pct = 0;
      g0 = grants;
      for (int i = 0; i < 5; i++) step(1'b0, '0);
      chk("t2_grants", grants - g0, DEPTH);
      chk("t2_req_off", {31'b0, imem_req}, 32'd0);
      chk("t2_head_pc", id_pc, 32'd0);
      rdy_pct = 100;
      d0 = delivered;
      for (int i = 0; i < 6; i++) step(1'b0, '0);
      chk("t2_drained", {31'b0, (delivered - d0 >= 2)}, 32'd1);

      // 3: redirect with fetches in flight
      dmin = 2; dmax = 2;
      for (int i = 0; i < 4; i++) step(1'b0, '0);
      step(1'b1, 32'h0000_0100);
      chk("t3_addr", imem_addr, 32'h0000_0100);
      wait_delivery("t3", 32'h0000_0100);

      // 4: redirect in the same cycle as a response, decode ready
      dmin = 1; dmax = 1;
      for (int i = 0; i < 20 && !(pend.size() > 0 && pend[0].due <= cyc); i++)
         step(1'b0, '0);
      chk("t4_rvalid_due", {31'b0, (pend.size() > 0)}, 32'd1);
      step(1'b1, 32'h0000_0200);
      wait_delivery("t4", 32'h0000_0200);

      // 5: misaligned redirect target and PC wrap
      step(1'b1, 32'h0000_0103);
      chk("t5_align", imem_addr, 32'h0000_0100);
      step(1'b1, 32'hFFFF_FFFC);
      chk("t5_top", imem_addr, 32'hFFFF_FFFC);
      g0 = grants;
      for (int i = 0; i < 20 && grants == g0; i++) step(1'b0, '0);
      chk("t5_wrap", imem_addr, 32'h0000_0000);
      wait_delivery("t5", 32'hFFFF_FFFC);

      // 6: random grants, latencies, stalls and redirects
      gnt_pct = 60; rdy_pct = 70; dmin = 1; dmax = 5;
      d0 = delivered;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 3)
            step(1'b1, $urandom());
         else
            step(1'b0, '0);
      end
      chk("t6_progress", {31'b0, (delivered - d0 > 100)}, 32'd1);

      // reset in the middle of traffic
      #2;
      do_reset("rst_mid");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
